seq_div6: RTL and testbench

SEQ_DIV6 -- requirements
Module: seq_div6

---
 rtl/seq_div6.sv | 204 ++++++++++++++++++++
 tb/tb_seq_div6.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div6.sv
// Sequential signed divider: 12-bit dividend / 6-bit divisor, truncating toward zero,
// six-cycle restoring core on magnitudes with sign fix-up, divide-by-zero and overflow flags.
module seq_div6 #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] dividend,
    input  logic signed [COEF_W-1:0] divisor,
    input  logic                     start,
    output logic                     ready,
    output logic signed [COEF_W-1:0] quotient,
    output logic signed [COEF_W-1:0] remainder,
    output logic                     dz,
    output logic                     ovf
);

    localparam int CNT_W = $clog2(COEF_W);
    localparam logic [COEF_W-1:0] NEG_LIM = COEF_W'(1) << (COEF_W - 1);
    localparam logic [COEF_W-1:0] POS_LIM = NEG_LIM - COEF_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic start_q;
    logic armed_q, armed_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [COEF_W-1:0] b_q, b_d;
    logic [COEF_W-1:0] bmag_q, bmag_d;
    logic [COEF_W-1:0] part_q, part_d;
    logic [COEF_W-1:0] lo_q, lo_d;
    logic [COEF_W-1:0] qmag_q, qmag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic signed [COEF_W-1:0] quo_q, quo_d;
    logic signed [COEF_W-1:0] rem_q, rem_d;
    logic dz_q, dz_d;
    logic ovf_q, ovf_d;

    logic trig;
    logic [DATA_W-1:0] amag;
    logic [COEF_W-1:0] bmag_new;
    logic [COEF_W:0] trial;
    logic trial_ge;

    function automatic logic [DATA_W-1:0] abs_dvd(input logic signed [DATA_W-1:0] v);
        // -2^(W-1) wraps to itself, which read unsigned is the correct magnitude
        abs_dvd = v[DATA_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [COEF_W-1:0] abs_dvs(input logic signed [COEF_W-1:0] v);
        abs_dvs = v[COEF_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic signed [COEF_W-1:0] apply_sign(input logic [COEF_W-1:0] m,
                                                            input logic neg);
        apply_sign = neg ? -$signed(m) : $signed(m);
    endfunction

    function automatic logic q_overflow(input logic [COEF_W-1:0] m, input logic neg);
        q_overflow = neg ? (m > NEG_LIM) : (m > POS_LIM);
    endfunction

    // armed_q blocks a start that was already high when reset released
    assign trig = start & ~start_q & armed_q &
                  ((state_q == S_IDLE) || (state_q == S_DONE));

    assign amag     = abs_dvd(a_q);
    assign bmag_new = abs_dvs(b_q);
    assign trial    = {part_q, lo_q[COEF_W-1]};
    assign trial_ge = (trial >= {1'b0, bmag_q});

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | ~start;
        a_d     = a_q;
        b_d     = b_q;
        bmag_d  = bmag_q;
        part_d  = part_q;
        lo_d    = lo_q;
        qmag_d  = qmag_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (trig) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    quo_d   = '0;
                    rem_d   = '0;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                bmag_d = bmag_new;
                qneg_d = a_q[DATA_W-1] ^ b_q[COEF_W-1];
                rneg_d = a_q[DATA_W-1];
                if (b_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else if (amag[DATA_W-1:COEF_W] >= bmag_new) begin
                    // quotient would need more than COEF_W magnitude bits
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    part_d  = amag[DATA_W-1:COEF_W];
                    lo_d    = amag[COEF_W-1:0];
                    qmag_d  = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                part_d = trial_ge ? COEF_W'(trial - {1'b0, bmag_q}) : trial[COEF_W-1:0];
                qmag_d = {qmag_q[COEF_W-2:0], trial_ge};
                lo_d   = {lo_q[COEF_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(COEF_W - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (q_overflow(qmag_q, qneg_q)) begin
                    ovf_d = 1'b1;
                    quo_d = '0;
                    rem_d = '0;
                end else begin
                    quo_d = apply_sign(qmag_q, qneg_q);
                    rem_d = apply_sign(part_q, rneg_q);
                end
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            bmag_q  <= '0;
            part_q  <= '0;
            lo_q    <= '0;
            qmag_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            armed_q <= armed_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bmag_q  <= bmag_d;
            part_q  <= part_d;
            lo_q    <= lo_d;
            qmag_q  <= qmag_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_div6.sv
// Randomized self-checking bench for seq_div6 against an integer-arithmetic reference model.
module tb_seq_div6;

    logic               clk;
    logic               rst;
    logic signed [11:0] dividend;
    logic signed [5:0]  divisor;
    logic               start;
    logic               ready;
    logic signed [5:0]  quotient;
    logic signed [5:0]  remainder;
    logic               dz;
    logic               ovf;

    int checks = 0;
    int fails  = 0;

    seq_div6 dut (
        .clk      (clk),
        .rst      (rst),
        .dividend (dividend),
        .divisor  (divisor),
        .start    (start),
        .ready    (ready),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    // Reference: plain integer division with the block's flag and latency rules.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int fdz,
                                  output int fov, output int lat);
        int aa, bb, qm, rm;
        bit neg;
        aa = (a < 0) ? -a : a;
        bb = (b < 0) ? -b : b;
        q = 0; r = 0; fdz = 0; fov = 0; lat = 8;
        if (b == 0) begin
            fdz = 1; lat = 1;
        end else if ((aa / 64) >= bb) begin
            fov = 1; lat = 1;
        end else begin
            qm  = aa / bb;
            rm  = aa % bb;
            neg = (a < 0) != (b < 0);
            if ((!neg && qm > 31) || (neg && qm > 32)) begin
                fov = 1;
            end else begin
                q = neg ? -qm : qm;
                r = (a < 0) ? -rm : rm;
            end
        end
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_vs_model(input int a, input int b, input int n, input string tag);
        int q, r, fdz, fov, lat;
        model(a, b, q, r, fdz, fov, lat);
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".q"}, quotient, q);
        chk({tag, ".r"}, remainder, r);
        chk({tag, ".dz"}, dz, fdz);
        chk({tag, ".ovf"}, ovf, fov);
    endtask

    task automatic run_op(input int a, input int b, input string tag);
        int n;
        dividend = 12'(a);
        divisor  = 6'(b);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(n);
        check_vs_model(a, b, n, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, low, falls, bb, a, b;
        logic prev;

        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", ready, 1);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dz", dz, 0);
        chk("rst.ovf", ovf, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(391, 17, "d391_17");
        chk("d391_17.q_const", quotient, 23);
        run_op(-341, 11, "dm341_11");
        chk("dm341_11.q_const", quotient, -31);
        run_op(-100, 7, "dm100_7");
        chk("dm100_7.r_const", remainder, -2);
        run_op(156, -13, "d156_m13");
        chk("d156_m13.q_const", quotient, -12);
        run_op(100, 0, "d100_0");
        chk("d100_0.dz_const", dz, 1);
        run_op(2047, 1, "d2047_1");
        run_op(64, 2, "d64_2");
        chk("d64_2.ovf_const", ovf, 1);
        run_op(-64, 2, "dm64_2");
        chk("dm64_2.q_const", quotient, -32);
        run_op(-2048, -32, "dm2048_m32");
        run_op(2047, 32 - 64, "d2047_m32");
        run_op(-2047, 31, "dm2047_31");

        // Second edge and operand change while busy
        dividend = 12'(300); divisor = 6'(7); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 12'(-1000); divisor = 6'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(n);
        check_vs_model(300, 7, n + 3, "busy_edge");
        repeat (3) @(posedge clk);
        #1;
        chk("busy_edge.no_queue", ready, 1);

        // Start held high for 20 cycles
        dividend = 12'(391); divisor = 6'(17); start = 1'b1;
        low = 0; falls = 0; prev = ready;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!ready) low++;
            if (prev && !ready) falls++;
            prev = ready;
        end
        start = 1'b0;
        chk("held.ops", falls, 1);
        chk("held.low_cycles", low, 8);
        chk("held.q", quotient, 23);
        @(posedge clk); #1;

        // Asynchronous reset while holding a result
        #2 rst = 1'b0;
        #1;
        chk("arst_done.q", quotient, 0);
        chk("arst_done.ready", ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the third DIV cycle
        dividend = 12'(500); divisor = 6'(9); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_div.ready", ready, 1);
        chk("arst_div.q", quotient, 0);
        chk("arst_div.r", remainder, 0);
        chk("arst_div.dz", dz, 0);
        chk("arst_div.ovf", ovf, 0);

        // Start already high at reset release must not fire
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        low = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!ready) low++;
        end
        chk("rel_held.low_cycles", low, 0);
        start = 1'b0;
        @(posedge clk); #1;
        run_op(20, -29, "d20_m29");
        chk("d20_m29.r_const", remainder, 20);

        for (int k = 0; k < 150; k++) begin
            b = int'($urandom_range(0, 63)) - 32;
            if ($urandom_range(0, 1) == 1 && b != 0) begin
                bb = (b < 0) ? -b : b;
                a  = int'($urandom_range(0, 64 * bb - 1));
                if ($urandom_range(0, 1) == 1) a = -a;
            end else begin
                a = int'($urandom_range(0, 4095)) - 2048;
            end
            run_op(a, b, $sformatf("rnd%0d_%0d_%0d", k, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
